mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one memory port between instruction fetch (IFU, read-only) and load/store (LSU, read/write) of the npc core.
- Sequences each access over valid/ready handshakes with one outstanding transaction.
- Generates byte write masks from MemOp and aligns/extends load data.
- Replaces the ideal combinational instr/data memories, so multi-cycle memory can sit behind the core.

Parameters:
- XLEN, 64, data and address width.
- IFU_W, 32, instruction width returned to IFU.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted this cycle
- ifu_req_addr  in  XLEN  fetch address, 4-byte aligned
- ifu_rsp_valid  out  1  one-cycle pulse, instruction valid
- ifu_rsp_data  out  IFU_W  instruction word
- lsu_req_valid  in  1  load/store request
- lsu_req_ready  out  1  load/store request accepted this cycle
- lsu_req_addr  in  XLEN  byte address
- lsu_req_wen  in  1  1 = store
- lsu_req_wdata  in  XLEN  store data, LSB-aligned
- lsu_req_memop  in  3  MemOp (000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu)
- lsu_rsp_valid  out  1  one-cycle pulse, load data valid or store done
- lsu_rsp_rdata  out  XLEN  aligned, extended load data (0 for stores)
- mem_req_valid  out  1  downstream request
- mem_req_ready  in  1  downstream accepts request
- mem_req_addr  out  XLEN  address with low 3 bits cleared
- mem_req_wen  out  1  write
- mem_req_wdata  out  XLEN  store data shifted to byte lane
- mem_req_wmask  out  XLEN/8  byte strobes
- mem_rsp_valid  in  1  downstream response
- mem_rsp_rdata  in  XLEN  raw doubleword

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output 0; owner/last_owner = IFU; any in-flight transaction is dropped and the downstream is reset with the core.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If any request is valid, grant one and assert only that requester's *_req_ready, combinationally, same cycle.
  - Latch addr, wen, wdata, memop and owner. Go to REQ.
  - Requesters hold their inputs until ready; nothing is required after acceptance.
- REQ: mem_req_valid=1 with latched fields, held stable until mem_req_ready=1; then go to WAIT.
- WAIT:
  - On mem_rsp_valid, register the processed response and go to RESP.
  - mem_rsp_valid is also returned for writes.
  - mem_rsp_valid in any state other than WAIT is ignored.
- RESP: owner's *_rsp_valid=1 for exactly one cycle; go to IDLE.
- Both *_req_ready are 0 outside IDLE and are never 1 together.
- Minimum latency, zero-wait memory: request accept at T, mem handshake at T+1, response at T+2, rsp_valid at T+3. Throughput is at most one access per 4 cycles.
- Arbitration, both valid in IDLE: LSU wins (fixed priority).
- Store mask: size = memop[1:0]; wmask = ((1<<(1<<size))-1) << addr[2:0]; wdata << 8*addr[2:0].
- Misalignment is not checked; lanes beyond bit 7 of the mask are truncated.
- Load data: raw >> 8*addr[2:0], then for memop[2]=0 sign-extend from the access size, for memop[2]=1 zero-extend; for 011 pass all 64 bits through.
- Fetch data: mem_rsp_rdata[63:32] when addr[2]=1, else [31:0].
- Output stability: ifu_rsp_data and lsu_rsp_rdata hold their last value until the next response of that requester.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both are valid in IDLE, grant the requester not recorded in last_owner; last_owner updates on every grant. A single valid requester is always granted.
- Undefined: fixed LSU priority, no last_owner register. An IFU starved by back-to-back LSU requests is acceptable because the single-issue core stalls fetch during LSU access.

Decomposition:
- Package mem_arb_pkg:
  - MemOp encoding constants (MEMOP_B … MEMOP_WU).
  - State enum (IDLE/REQ/WAIT/RESP).
  - Owner encoding (OWN_IFU=0, OWN_LSU=1).
- Sub-module mem_lsu_align, purely combinational:
  - Store side: memop, addr[2:0], wdata -> wmask and shifted wdata.
  - Load side: memop, addr[2:0], raw rdata -> extended rdata.
- FSM and arbitration stay in mem_arbiter.

Test Plan:
- IFU fetch, addr 0x80000004, zero-wait memory returns 0x0000_0013_1234_5678 -> ifu_req_ready at T, mem_req_addr 0x80000000, ifu_rsp_valid at T+3, data 0x00000013.
- Both valid in same cycle (macro off) -> lsu_req_ready=1, ifu_req_ready=0; IFU is granted in the next IDLE after the LSU response.
- LSU sb, addr 0x...3, wdata 0xAB -> mem_req_wmask 0x08, mem_req_wdata 0xAB000000, lsu_rsp_valid pulse, rdata 0.
- LSU lh, addr 0x...6, raw 0x8001_xxxx_xxxx_xxxx -> rdata 0xFFFF_FFFF_FFFF_8001; lhu -> 0x8001.
- mem_req_ready held low 5 cycles -> mem_req_valid and fields stable throughout; a new lsu_req_valid sees ready=0. rst_n pulsed low in WAIT -> all outputs 0 immediately, IDLE after release, no rsp pulse.
- MEM_ARB_RR_EN defined, both requesters continuously valid -> grants alternate LSU, IFU, LSU, IFU.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory arbiter: MemOp codes, FSM states, owner ids.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    // MemOp: bits [1:0] give log2(access bytes), bit 2 selects zero-extension
    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_D  = 3'b011;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;
    localparam logic [2:0] MEMOP_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the IFU, LSU and downstream memory handshakes around mem_arbiter.
// Latency: n/a (wires only).
// Backpressure: valid/ready on requests; responses are single-cycle pulses.
// Modports: slave = the arbiter's view (serves IFU/LSU, drives memory);
//           master = the environment's view (requesters plus memory model).
interface mem_arbiter_if #(
    parameter int XLEN  = 64,
    parameter int IFU_W = 32
);
    // instruction fetch
    logic                ifu_req_valid;
    logic                ifu_req_ready;
    logic [XLEN-1:0]     ifu_req_addr;
    logic                ifu_rsp_valid;
    logic [IFU_W-1:0]    ifu_rsp_data;
    // load/store
    logic                lsu_req_valid;
    logic                lsu_req_ready;
    logic [XLEN-1:0]     lsu_req_addr;
    logic                lsu_req_wen;
    logic [XLEN-1:0]     lsu_req_wdata;
    logic [2:0]          lsu_req_memop;
    logic                lsu_rsp_valid;
    logic [XLEN-1:0]     lsu_rsp_rdata;
    // downstream memory
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [XLEN-1:0]     mem_req_addr;
    logic                mem_req_wen;
    logic [XLEN-1:0]     mem_req_wdata;
    logic [XLEN/8-1:0]   mem_req_wmask;
    logic                mem_rsp_valid;
    logic [XLEN-1:0]     mem_rsp_rdata;

    modport slave (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_memop,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport master (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_memop,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

endinterface

// File: rtl/mem_lsu_align.sv
// Byte-lane alignment for LSU traffic: store mask/data shift, load shift/extend.
// Latency: purely combinational.
// Backpressure: none (no handshake).
// Ports: memop_i, off_i (addr[2:0]), wdata_i, rdata_i -> wmask_o, wdata_o, rdata_o.
module mem_lsu_align
    import mem_arb_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]        memop_i,
    input  logic [2:0]        off_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic [XLEN/8-1:0] wmask_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN-1:0]   rdata_o
);

    logic [7:0]      base_mask;
    logic [15:0]     wide_mask;
    logic [XLEN-1:0] shifted;

    // Store side: lanes pushed past byte 7 by a misaligned access fall off.
    always_comb begin
        base_mask = 8'h01;
        case (memop_i[1:0])
            2'd0:    base_mask = 8'h01;
            2'd1:    base_mask = 8'h03;
            2'd2:    base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
        wide_mask = {8'h00, base_mask} << off_i;
        wmask_o   = wide_mask[7:0];
        wdata_o   = wdata_i << {off_i, 3'b000};
    end

    // Load side: bring the addressed byte to lane 0, then extend by size.
    always_comb begin
        shifted = rdata_i >> {off_i, 3'b000};
        case (memop_i)
            MEMOP_B:  rdata_o = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            MEMOP_H:  rdata_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            MEMOP_W:  rdata_o = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            MEMOP_BU: rdata_o = {{(XLEN-8){1'b0}},         shifted[7:0]};
            MEMOP_HU: rdata_o = {{(XLEN-16){1'b0}},        shifted[15:0]};
            MEMOP_WU: rdata_o = {{(XLEN-32){1'b0}},        shifted[31:0]};
            default:  rdata_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU fetch and LSU load/store, one access in flight.
// Latency: accept T, mem handshake T+1 (zero-wait), mem response T+2, rsp_valid T+3.
// Backpressure: req_ready only in IDLE; mem_req held stable until mem_req_ready.
// Ports: clk, rst_n (async active-low), bus (mem_arbiter_if.slave).
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; default is fixed LSU priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int IFU_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_arbiter_if.slave      bus
);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [2:0]          memop_q, memop_d;
    logic [IFU_W-1:0]    ifu_data_q, ifu_data_d;
    logic [XLEN-1:0]     lsu_data_q, lsu_data_d;

    logic                pick_lsu;
    logic                grant_ifu;
    logic                grant_lsu;

    logic [XLEN/8-1:0]   al_wmask;
    logic [XLEN-1:0]     al_wdata;
    logic [XLEN-1:0]     al_rdata;

    mem_lsu_align #(.XLEN(XLEN)) u_align (
        .memop_i (memop_q),
        .off_i   (addr_q[2:0]),
        .wdata_i (wdata_q),
        .rdata_i (bus.mem_rsp_rdata),
        .wmask_o (al_wmask),
        .wdata_o (al_wdata),
        .rdata_o (al_rdata)
    );

    // ---------------- arbitration ----------------
`ifdef MEM_ARB_RR_EN
    owner_e last_owner_q;

    // On contention, serve whoever did not get the previous grant.
    always_comb begin
        if (bus.lsu_req_valid && bus.ifu_req_valid) begin
            pick_lsu = (last_owner_q == OWN_IFU);
        end else begin
            pick_lsu = bus.lsu_req_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= OWN_IFU;
        end else if (grant_lsu) begin
            last_owner_q <= OWN_LSU;
        end else if (grant_ifu) begin
            last_owner_q <= OWN_IFU;
        end
    end
`else
    // Fixed priority: the single-issue core stalls fetch behind LSU anyway.
    assign pick_lsu = bus.lsu_req_valid;
`endif

    // Readies are combinational; gating with rst_n keeps them low while reset
    // is held even though IDLE would otherwise accept a waiting request.
    assign grant_lsu = rst_n && (state_q == IDLE) && bus.lsu_req_valid && pick_lsu;
    assign grant_ifu = rst_n && (state_q == IDLE) && bus.ifu_req_valid && !pick_lsu;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IFU;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            memop_q    <= '0;
            ifu_data_q <= '0;
            lsu_data_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            memop_q    <= memop_d;
            ifu_data_q <= ifu_data_d;
            lsu_data_q <= lsu_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        memop_d    = memop_q;
        ifu_data_d = ifu_data_q;
        lsu_data_d = lsu_data_q;

        case (state_q)
            IDLE: begin
                if (grant_lsu) begin
                    addr_d  = bus.lsu_req_addr;
                    wen_d   = bus.lsu_req_wen;
                    wdata_d = bus.lsu_req_wdata;
                    memop_d = bus.lsu_req_memop;
                    owner_d = OWN_LSU;
                    state_d = REQ;
                end else if (grant_ifu) begin
                    addr_d  = bus.ifu_req_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    memop_d = MEMOP_WU;
                    owner_d = OWN_IFU;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_rsp_valid) begin
                    if (owner_q == OWN_LSU) begin
                        // Writes also get a response; they return zero data.
                        lsu_data_d = wen_q ? '0 : al_rdata;
                    end else begin
                        ifu_data_d = addr_q[2] ? bus.mem_rsp_rdata[2*IFU_W-1:IFU_W]
                                               : bus.mem_rsp_rdata[IFU_W-1:0];
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- outputs ----------------
    assign bus.ifu_req_ready = grant_ifu;
    assign bus.lsu_req_ready = grant_lsu;

    assign bus.mem_req_valid = (state_q == REQ);
    assign bus.mem_req_addr  = {addr_q[XLEN-1:3], 3'b000};
    assign bus.mem_req_wen   = wen_q;
    assign bus.mem_req_wdata = wen_q ? al_wdata : '0;
    assign bus.mem_req_wmask = wen_q ? al_wmask : '0;

    assign bus.ifu_rsp_valid = (state_q == RESP) && (owner_q == OWN_IFU);
    assign bus.ifu_rsp_data  = ifu_data_q;
    assign bus.lsu_rsp_valid = (state_q == RESP) && (owner_q == OWN_LSU);
    assign bus.lsu_rsp_rdata = lsu_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, loads/stores, contention, stall, reset.
// Latency: n/a (testbench).
// Backpressure: memory model can hold mem_req_ready low or withhold responses.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk;
    logic rst_n;

    mem_arbiter_if #(.XLEN(64), .IFU_W(32)) bus ();

    mem_arbiter #(.XLEN(64), .IFU_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errs   = 0;
    logic [63:0] mem_data = 64'h0;
    logic        mem_silent = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Zero-wait memory: answers in the cycle after a handshake.
    initial begin : mem_model
        logic hs;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 64'h0;
        forever begin
            @(negedge clk);
            hs = bus.mem_req_valid && bus.mem_req_ready && !mem_silent;
            @(posedge clk);
            #1;
            bus.mem_rsp_valid = hs;
            if (hs) bus.mem_rsp_rdata = mem_data;
        end
    end

    // Called in IDLE at posedge+1; returns in IDLE at posedge+1.
    task automatic ifu_fetch(input string tag, input logic [63:0] addr,
                             input logic [63:0] raw, input logic [31:0] exp);
        mem_data          = raw;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = addr;
        @(negedge clk);
        chk({tag, ".ifu_rdy"}, bus.ifu_req_ready, 1);
        chk({tag, ".lsu_rdy"}, bus.lsu_req_ready, 0);
        tick;
        bus.ifu_req_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".mvld"}, bus.mem_req_valid, 1);
        chk({tag, ".maddr"}, bus.mem_req_addr, addr & ~64'h7);
        tick;
        @(negedge clk);
        chk({tag, ".early"}, bus.ifu_rsp_valid, 0);
        tick;
        @(negedge clk);
        chk({tag, ".rvld"}, bus.ifu_rsp_valid, 1);
        chk({tag, ".data"}, bus.ifu_rsp_data, exp);
        tick;
        @(negedge clk);
        chk({tag, ".pulse"}, bus.ifu_rsp_valid, 0);
        chk({tag, ".hold"}, bus.ifu_rsp_data, exp);
        tick;
    endtask

    task automatic lsu_access(input string tag, input logic wen, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [2:0] op,
                              input logic [63:0] raw, input logic [7:0] emask,
                              input logic [63:0] ewdata, input logic [63:0] erdata);
        mem_data          = raw;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_addr  = addr;
        bus.lsu_req_wen   = wen;
        bus.lsu_req_wdata = wdata;
        bus.lsu_req_memop = op;
        @(negedge clk);
        chk({tag, ".lsu_rdy"}, bus.lsu_req_ready, 1);
        tick;
        bus.lsu_req_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".mvld"}, bus.mem_req_valid, 1);
        chk({tag, ".maddr"}, bus.mem_req_addr, addr & ~64'h7);
        chk({tag, ".wen"}, bus.mem_req_wen, wen);
        chk({tag, ".wmask"}, bus.mem_req_wmask, emask);
        chk({tag, ".wdata"}, bus.mem_req_wdata, ewdata);
        tick;
        tick;
        @(negedge clk);
        chk({tag, ".rvld"}, bus.lsu_rsp_valid, 1);
        chk({tag, ".rdata"}, bus.lsu_rsp_rdata, erdata);
        tick;
        @(negedge clk);
        chk({tag, ".pulse"}, bus.lsu_rsp_valid, 0);
        tick;
    endtask

    initial begin : main
        logic exp_lsu;
        rst_n             = 1'b0;
        bus.ifu_req_valid = 1'b0;
        bus.ifu_req_addr  = 64'h0;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_req_addr  = 64'h0;
        bus.lsu_req_wen   = 1'b0;
        bus.lsu_req_wdata = 64'h0;
        bus.lsu_req_memop = 3'b000;
        bus.mem_req_ready = 1'b1;

        // reset state
        tick;
        tick;
        @(negedge clk);
        chk("rst.mvld", bus.mem_req_valid, 0);
        chk("rst.maddr", bus.mem_req_addr, 0);
        chk("rst.ifu_rvld", bus.ifu_rsp_valid, 0);
        chk("rst.lsu_rvld", bus.lsu_rsp_valid, 0);
        chk("rst.ifu_data", bus.ifu_rsp_data, 0);
        chk("rst.lsu_rdata", bus.lsu_rsp_rdata, 0);
        rst_n = 1'b1;
        tick;

        // fetch from the upper word
        ifu_fetch("fetch", 64'h8000_0004, 64'h0000_0013_1234_5678, 32'h0000_0013);

        // contention: LSU wins, IFU follows in the next IDLE
        mem_data          = 64'h0000_0000_DEAD_BEEF;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 64'h8000_0010;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_addr  = 64'h8000_0020;
        bus.lsu_req_wen   = 1'b0;
        bus.lsu_req_memop = MEMOP_WU;
        @(negedge clk);
        chk("both.lsu_rdy", bus.lsu_req_ready, 1);
        chk("both.ifu_rdy", bus.ifu_req_ready, 0);
        tick;
        bus.lsu_req_valid = 1'b0;
        @(negedge clk);
        chk("both.maddr", bus.mem_req_addr, 64'h8000_0020);
        chk("both.ifu_rdy_req", bus.ifu_req_ready, 0);
        tick;
        tick;
        @(negedge clk);
        chk("both.lsu_rvld", bus.lsu_rsp_valid, 1);
        chk("both.lsu_rdata", bus.lsu_rsp_rdata, 64'hDEAD_BEEF);
        chk("both.ifu_rdy_resp", bus.ifu_req_ready, 0);
        tick;
        @(negedge clk);
        chk("both.ifu_rdy_idle", bus.ifu_req_ready, 1);
        tick;
        bus.ifu_req_valid = 1'b0;
        @(negedge clk);
        chk("both.ifu_maddr", bus.mem_req_addr, 64'h8000_0010);
        tick;
        tick;
        @(negedge clk);
        chk("both.ifu_rvld", bus.ifu_rsp_valid, 1);
        chk("both.ifu_data", bus.ifu_rsp_data, 32'hDEAD_BEEF);
        tick;

        // stores and loads
        lsu_access("sb", 1'b1, 64'h8000_0003, 64'hAB, MEMOP_B, 64'h0,
                   8'h08, 64'hAB00_0000, 64'h0);
        lsu_access("sh_mis", 1'b1, 64'h8000_0007, 64'hBEEF, MEMOP_H, 64'h0,
                   8'h80, 64'hEF00_0000_0000_0000, 64'h0);
        lsu_access("sd", 1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, MEMOP_D, 64'h0,
                   8'hFF, 64'h1122_3344_5566_7788, 64'h0);
        lsu_access("lh", 1'b0, 64'h8000_0006, 64'h0, MEMOP_H, 64'h8001_0000_0000_0000,
                   8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001);
        lsu_access("lhu", 1'b0, 64'h8000_0006, 64'h0, MEMOP_HU, 64'h8001_0000_0000_0000,
                   8'h00, 64'h0, 64'h0000_0000_0000_8001);
        lsu_access("lw", 1'b0, 64'h8000_0004, 64'h0, MEMOP_W, 64'h8000_0000_1234_5678,
                   8'h00, 64'h0, 64'hFFFF_FFFF_8000_0000);
        lsu_access("lwu", 1'b0, 64'h8000_0004, 64'h0, MEMOP_WU, 64'h8000_0000_1234_5678,
                   8'h00, 64'h0, 64'h0000_0000_8000_0000);
        lsu_access("lb", 1'b0, 64'h8000_0005, 64'h0, MEMOP_B, 64'h0000_8000_0000_0000,
                   8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80);
        lsu_access("lbu", 1'b0, 64'h8000_0005, 64'h0, MEMOP_BU, 64'h0000_8000_0000_0000,
                   8'h00, 64'h0, 64'h0000_0000_0000_0080);
        lsu_access("ld", 1'b0, 64'h8000_0000, 64'h0, MEMOP_D, 64'hCAFE_F00D_0123_4567,
                   8'h00, 64'h0, 64'hCAFE_F00D_0123_4567);

        // downstream stall: request held stable, new requests see ready=0
        bus.mem_req_ready = 1'b0;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_addr  = 64'h8000_0040;
        bus.lsu_req_wen   = 1'b1;
        bus.lsu_req_wdata = 64'h0102_0304_0506_0708;
        bus.lsu_req_memop = MEMOP_D;
        @(negedge clk);
        chk("stall.lsu_rdy", bus.lsu_req_ready, 1);
        tick;
        bus.lsu_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) bus.lsu_req_valid = 1'b1;
            @(negedge clk);
            chk("stall.mvld", bus.mem_req_valid, 1);
            chk("stall.maddr", bus.mem_req_addr, 64'h8000_0040);
            chk("stall.wmask", bus.mem_req_wmask, 8'hFF);
            chk("stall.wdata", bus.mem_req_wdata, 64'h0102_0304_0506_0708);
            if (i >= 2) chk("stall.new_rdy", bus.lsu_req_ready, 0);
            tick;
        end
        bus.lsu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        chk("stall.mvld_end", bus.mem_req_valid, 1);
        tick;
        tick;
        @(negedge clk);
        chk("stall.rvld", bus.lsu_rsp_valid, 1);
        chk("stall.rdata", bus.lsu_rsp_rdata, 0);
        tick;
        tick;

        // reset asserted while waiting for the memory response
        mem_silent        = 1'b1;
        mem_data          = 64'h0000_0000_0000_0073;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 64'h8000_0008;
        @(negedge clk);
        chk("rstw.ifu_rdy", bus.ifu_req_ready, 1);
        tick;
        bus.ifu_req_valid = 1'b0;
        tick;
        @(negedge clk);
        chk("rstw.in_wait", bus.mem_req_valid, 0);
        bus.ifu_req_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstw.ifu_rdy0", bus.ifu_req_ready, 0);
        chk("rstw.lsu_rdy0", bus.lsu_req_ready, 0);
        chk("rstw.mvld0", bus.mem_req_valid, 0);
        chk("rstw.maddr0", bus.mem_req_addr, 0);
        chk("rstw.ifu_data0", bus.ifu_rsp_data, 0);
        chk("rstw.lsu_rdata0", bus.lsu_rsp_rdata, 0);
        tick;
        tick;
        @(negedge clk);
        chk("rstw.no_rvld", bus.ifu_rsp_valid, 0);
        rst_n      = 1'b1;
        mem_silent = 1'b0;
        #1;
        chk("rstw.idle_rdy", bus.ifu_req_ready, 1);
        tick;
        bus.ifu_req_valid = 1'b0;
        tick;
        tick;
        @(negedge clk);
        chk("rstw.rvld", bus.ifu_rsp_valid, 1);
        chk("rstw.data", bus.ifu_rsp_data, 32'h0000_0073);
        tick;

        // both requesters held valid: alternation with round-robin, LSU every time otherwise
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 64'h8000_0100;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_addr  = 64'h8000_0200;
        bus.lsu_req_wen   = 1'b0;
        bus.lsu_req_memop = MEMOP_D;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            exp_lsu = ((k % 2) == 0);
`else
            exp_lsu = 1'b1;
`endif
            @(negedge clk);
            chk("arb.lsu_rdy", bus.lsu_req_ready, exp_lsu);
            chk("arb.ifu_rdy", bus.ifu_req_ready, !exp_lsu);
            tick;
            tick;
            tick;
            tick;
        end
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        tick;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
